// File: rtl/wb_write_queue_if.sv
// Register-file write-side bundle: pipeline writeback, late-result push,
// registered register-file write and the decode pending-write lookup.
interface wb_write_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          pipe_we;
    logic [AW-1:0] pipe_waddr;
    logic [DW-1:0] pipe_wdata;
    logic          pipe_stall;

    logic          lsu_valid;
    logic [AW-1:0] lsu_waddr;
    logic [DW-1:0] lsu_wdata;
    logic          lsu_ready;

    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    logic [AW-1:0] chk_addr1;
    logic [AW-1:0] chk_addr2;
    logic          chk_hit1;
    logic          chk_hit2;

    // The write queue drives the register file port.
    modport master (
        input  pipe_we, pipe_waddr, pipe_wdata,
        output pipe_stall,
        input  lsu_valid, lsu_waddr, lsu_wdata,
        output lsu_ready,
        output rf_we, rf_waddr, rf_wdata,
        input  chk_addr1, chk_addr2,
        output chk_hit1, chk_hit2
    );

    modport slave (
        output pipe_we, pipe_waddr, pipe_wdata,
        input  pipe_stall,
        output lsu_valid, lsu_waddr, lsu_wdata,
        input  lsu_ready,
        input  rf_we, rf_waddr, rf_wdata,
        output chk_addr1, chk_addr2,
        input  chk_hit1, chk_hit2
    );
endinterface

// File: rtl/wb_write_queue.sv
// Register-file write arbiter: pipeline writeback wins, late results queue in a FIFO.
// Define WBQ_STARVE_GUARD_EN to force the queue head after STARVE_MAX preempted cycles.
module wb_write_queue #(
    parameter int DEPTH      = 4,
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_write_queue_if.master       bus,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_bad_params
        $error("wb_write_queue: DEPTH must be a power of two in 2..16 and STARVE_MAX >= 1");
    end

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;

    logic          rf_we_reg, rf_we_next;
    logic [AW-1:0] rf_waddr_reg, rf_waddr_next;
    logic [DW-1:0] rf_wdata_reg, rf_wdata_next;

    logic          fifo_empty;
    logic          fifo_full;
    logic          pipe_req;
    logic          pipe_win;
    logic          push;
    logic          pop;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CW'(DEPTH));
    assign head_addr  = addr_mem[rd_ptr_reg];
    assign head_data  = data_mem[rd_ptr_reg];

    // A write to r0 is no write at all, so it never blocks the queue.
    assign pipe_req = bus.pipe_we && (bus.pipe_waddr != '0);
    assign pipe_win = pipe_req && !bus.pipe_stall;
    assign pop      = !pipe_win && !fifo_empty;

    // Ready looks only at the registered count; a same-cycle pop does not open a slot.
    assign bus.lsu_ready = !fifo_full && !rst;
    assign push          = bus.lsu_valid && bus.lsu_ready && (bus.lsu_waddr != '0);

`ifdef WBQ_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_reg, starve_next;

    always_comb begin
        starve_next = '0;
        if (!fifo_empty && pipe_win) begin
            starve_next = starve_reg + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
        end
    end

    assign bus.pipe_stall = pipe_req && !fifo_empty && (starve_reg == SW'(STARVE_MAX));
`else
    assign bus.pipe_stall = 1'b0;
`endif

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        rf_we_next    = 1'b0;
        rf_waddr_next = rf_waddr_reg;
        rf_wdata_next = rf_wdata_reg;
        if (pipe_win) begin
            rf_we_next    = 1'b1;
            rf_waddr_next = bus.pipe_waddr;
            rf_wdata_next = bus.pipe_wdata;
        end else if (pop) begin
            rf_we_next    = 1'b1;
            rf_waddr_next = head_addr;
            rf_wdata_next = head_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            rf_we_reg    <= rf_we_next;
            rf_waddr_reg <= rf_waddr_next;
            rf_wdata_reg <= rf_wdata_next;
        end
    end

    // Entry storage needs no reset: validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= bus.lsu_waddr;
            data_mem[wr_ptr_reg] <= bus.lsu_wdata;
        end
    end

    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] hit1_vec;
    logic [DEPTH-1:0] hit2_vec;

    // Slot gi is occupied when its distance from the read pointer is below count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [PW-1:0] age;
        assign age             = PW'(gi) - rd_ptr_reg;
        assign entry_valid[gi] = ({1'b0, age} < count_reg);
        assign hit1_vec[gi]    = entry_valid[gi] && (addr_mem[gi] == bus.chk_addr1);
        assign hit2_vec[gi]    = entry_valid[gi] && (addr_mem[gi] == bus.chk_addr2);
    end

    assign bus.chk_hit1 = (bus.chk_addr1 != '0) && (|hit1_vec);
    assign bus.chk_hit2 = (bus.chk_addr2 != '0) && (|hit2_vec);

    assign bus.rf_we    = rf_we_reg;
    assign bus.rf_waddr = rf_waddr_reg;
    assign bus.rf_wdata = rf_wdata_reg;
    assign count        = count_reg;
endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Write-side master for the register file's single write port.
- Merges two result producers onto that port:
  - the in-order pipeline writeback, which always has priority;
  - late results (AXI load data, multi-cycle divide), which are buffered in a small FIFO.
- Issues at most one register write per cycle.
- Gives the hazard unit a pending-write lookup, so decode can stall on registers whose late result has not yet been written.

Parameters:
- DEPTH, 4, late-result FIFO entries (power of two, 2..16).
- AW, 5, register address width.
- DW, 32, register data width.
- STARVE_MAX, 8, consecutive preempted cycles before the queue head is forced (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pipe_we  in  1  pipeline writeback valid.
- pipe_waddr  in  AW  pipeline destination register.
- pipe_wdata  in  DW  pipeline result.
- pipe_stall  out  1  pipeline write not accepted this cycle; hold it.
- lsu_valid  in  1  late result valid.
- lsu_waddr  in  AW  late result destination.
- lsu_wdata  in  DW  late result data.
- lsu_ready  out  1  FIFO can accept a late result.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  AW  register file write address (registered).
- rf_wdata  out  DW  register file write data (registered).
- chk_addr1  in  AW  decode source 1 lookup address.
- chk_addr2  in  AW  decode source 2 lookup address.
- chk_hit1  out  1  a queued entry targets chk_addr1.
- chk_hit2  out  1  a queued entry targets chk_addr2.
- count  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst=1): FIFO emptied, count=0, rf_we=0, rf_waddr=0, rf_wdata=0, lsu_ready=0, chk_hit*=0, pipe_stall=0.
  - lsu_ready rises the first cycle after rst deasserts.
  - An entry in flight when reset asserts is lost; no write is issued.
- Write selection, once per rising edge. Registered outputs reflect the selection one cycle later (latency 1):
  - pipe_we=1, pipe_waddr!=0, not stalled: rf_* <= pipe data; FIFO head not popped.
  - Otherwise, FIFO non-empty: rf_* <= head entry; pop.
  - Otherwise: rf_we <= 0; rf_waddr and rf_wdata hold their previous values.
  - pipe_we with pipe_waddr=0: treated as no write; the queue may pop that cycle.
- Push:
  - lsu_ready = (count < DEPTH) and not rst. Combinational from registered count only, with no same-cycle pop lookahead.
  - Handshake is lsu_valid && lsu_ready. Entries with lsu_waddr=0 are accepted and discarded (not stored, count unchanged).
- Push and pop in the same cycle: count unchanged, pointers both advance; legal at count=DEPTH-1.
  - At count=DEPTH, lsu_ready=0 even if a pop occurs.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count never exceeds DEPTH or underflows.
- chk_hitN:
  - Combinational OR over valid stored entries of (entry_addr==chk_addrN), forced 0 when chk_addrN=0.
  - Excludes the entry being pushed this cycle and the registered rf_* write, which the register file bypasses.
- Ordering: late results drain in FIFO order.
- Precondition, not checked: the pipeline never writes an address with a pending queued entry (decode stalls on chk_hit).

Optional Feature:
- Macro: WBQ_STARVE_GUARD_EN.
- Defined:
  - A counter tracks consecutive cycles in which the FIFO is non-empty and a pipeline write wins. It resets to 0 on any pop or on empty.
  - When the counter reaches STARVE_MAX: pipe_stall=1 combinationally that cycle, the head is popped instead, and the counter clears. The pipeline must hold its write valid and data.
- Not defined: no counter; pipe_stall tied 0; the pipeline always wins, so the FIFO can starve (back-pressure via lsu_ready only).

Test Plan:
- Reset release, lsu_valid pulses with addr=3, data=0xDEADBEEF, pipe idle -> lsu_ready=1 after reset; chk_hit1=1 for chk_addr1=3 for exactly one cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF; count returns to 0.
- Fill DEPTH=4 entries (addrs 1..4) while pipe_we=1 every cycle (addr 10) -> count=4, lsu_ready=0; all rf writes go to addr 10. Drop pipe_we -> four writes to addrs 1,2,3,4 in order on consecutive cycles.
- At count=3 push and pop in the same cycle -> count stays 3 and lsu_ready stays 1. At count=4 -> lsu_ready=0, no push.
- pipe_we=1 with pipe_waddr=0 while FIFO holds addr 7 -> next cycle rf_waddr=7. lsu write to addr 0 -> accepted, count unchanged, no rf write.
- Assert rst mid-drain with count=2 -> outputs zero immediately (async); after release count=0 and no stale writes appear.
- With WBQ_STARVE_GUARD_EN, STARVE_MAX=8, FIFO non-empty and pipe_we held high -> pipe_stall=1 on the 9th cycle, head written, held pipe write accepted the following cycle. Without the macro -> pipe_stall never asserts.
